// File: rtl/latch_sr_with_enable_nor.sv
// Clocked gated NOR SR latch with optional input synchronizer (SYNC_STAGES).
// Optional sticky forbidden_seen output when LATCH_SR_FORBIDDEN_STICKY_EN is defined.
module latch_sr_with_enable_nor #(
  parameter int SYNC_STAGES = 0,
  parameter bit RESET_Q     = 1'b0
) (
  input  logic clock,
  input  logic async_reset,
  input  logic enable,
  input  logic set,
  input  logic reset,
  output logic signal_q,
  output logic signal_q_,
`ifdef LATCH_SR_FORBIDDEN_STICKY_EN
  output logic forbidden_seen,
`endif
  output logic forbidden
);

  // Encoding is {Q, Q_}, so the outputs are the state flops themselves.
  typedef enum logic [1:0] {
    ST_FORBID = 2'b00,
    ST_RESET  = 2'b01,
    ST_SET    = 2'b10
  } state_e;

  localparam state_e RESET_ST = RESET_Q ? ST_SET : ST_RESET;

  logic   enS;
  logic   setS;
  logic   resetS;
  state_e stateQ;
  state_e stateD;
  logic   forbiddenQ;

  generate
    if (SYNC_STAGES == 0) begin : gNoSync
      assign enS    = enable;
      assign setS   = set;
      assign resetS = reset;
    end else begin : gSync
      logic [2:0] syncQ [SYNC_STAGES];

      always_ff @(posedge clock or posedge async_reset) begin
        if (async_reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) syncQ[i] <= 3'b000;
        end else begin
          syncQ[0] <= {enable, set, reset};
          for (int i = 1; i < SYNC_STAGES; i++) syncQ[i] <= syncQ[i-1];
        end
      end

      assign {enS, setS, resetS} = syncQ[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      stateQ     <= RESET_ST;
      forbiddenQ <= 1'b0;
    end else begin
      stateQ     <= stateD;
      forbiddenQ <= (stateD == ST_FORBID);
    end
  end

  // Leaving the forbidden state without a single S or R resolves to reset,
  // standing in for the metastable race of a real NOR pair.
  always_comb begin
    stateD = stateQ;
    if (enS && setS && resetS) begin
      stateD = ST_FORBID;
    end else if (enS && setS) begin
      stateD = ST_SET;
    end else if (enS && resetS) begin
      stateD = ST_RESET;
    end else if (stateQ == ST_FORBID) begin
      stateD = ST_RESET;
    end
  end

  always_comb begin
    signal_q  = stateQ[1];
    signal_q_ = stateQ[0];
    forbidden = forbiddenQ;
  end

`ifdef LATCH_SR_FORBIDDEN_STICKY_EN
  logic forbiddenSeenQ;

  always_ff @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      forbiddenSeenQ <= 1'b0;
    end else begin
      forbiddenSeenQ <= forbiddenSeenQ | (stateD == ST_FORBID);
    end
  end

  assign forbidden_seen = forbiddenSeenQ;
`endif

endmodule

// File: tb/tb_latch_sr_with_enable_nor.sv
// Self-checking bench for latch_sr_with_enable_nor: directed vector table,
// hand-written reset/latency sequences and a randomized run against a reference model.
module tb_latch_sr_with_enable_nor;

  localparam int SYNC    = 2;
  localparam bit RESET_Q = 1'b0;
  localparam int HOLD    = 10;

  logic clock;
  logic async_reset;
  logic enable;
  logic set;
  logic reset;
  logic signal_q;
  logic signal_q_;
  logic forbidden;
`ifdef LATCH_SR_FORBIDDEN_STICKY_EN
  logic forbidden_seen;
`endif

  int vectors;
  int miscompares;

  latch_sr_with_enable_nor #(
    .SYNC_STAGES(SYNC),
    .RESET_Q    (RESET_Q)
  ) dut (
    .clock         (clock),
    .async_reset   (async_reset),
    .enable        (enable),
    .set           (set),
    .reset         (reset),
    .signal_q      (signal_q),
    .signal_q_     (signal_q_),
`ifdef LATCH_SR_FORBIDDEN_STICKY_EN
    .forbidden_seen(forbidden_seen),
`endif
    .forbidden     (forbidden)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference model: inputs seen SYNC edges ago decide the latch state
  // using the gated NOR latch truth table with reset-dominant resolution.
  bit [2:0] hist [SYNC];
  bit       mq;
  bit       mqb;
  bit       mSeen;
  bit [2:0] cur;

  always @(posedge clock or posedge async_reset) begin
    if (async_reset) begin
      mq    = RESET_Q;
      mqb   = ~RESET_Q;
      mSeen = 1'b0;
      for (int i = 0; i < SYNC; i++) hist[i] = 3'b000;
    end else begin
      cur = hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = {enable, set, reset};
      if (cur == 3'b111) begin
        mq = 1'b0; mqb = 1'b0;
      end else if (cur == 3'b110) begin
        mq = 1'b1; mqb = 1'b0;
      end else if (cur == 3'b101) begin
        mq = 1'b0; mqb = 1'b1;
      end else if (!mq && !mqb) begin
        mq = 1'b0; mqb = 1'b1;
      end
      if (!mq && !mqb) mSeen = 1'b1;
    end
  end

  typedef struct {
    bit    en;
    bit    s;
    bit    r;
    bit    expQ;
    bit    expQb;
    bit    expF;
    string name;
  } vec_t;

  vec_t table_v [14];

  task automatic checkOutput(input string tag, input bit eq, input bit eqb, input bit ef);
    vectors++;
    if (signal_q !== eq || signal_q_ !== eqb || forbidden !== ef) begin
      miscompares++;
      $display("[TB] FAIL %s: got q=%b q_=%b forbidden=%b, expected q=%b q_=%b forbidden=%b",
               tag, signal_q, signal_q_, forbidden, eq, eqb, ef);
    end
  endtask

  task automatic checkModel(input string tag);
    checkOutput(tag, mq, mqb, (!mq && !mqb));
`ifdef LATCH_SR_FORBIDDEN_STICKY_EN
    vectors++;
    if (forbidden_seen !== mSeen) begin
      miscompares++;
      $display("[TB] FAIL %s forbidden_seen: got %b, expected %b", tag, forbidden_seen, mSeen);
    end
`endif
  endtask

  task automatic applyStimulus(input bit en, input bit s, input bit r);
    enable = en;
    set    = s;
    reset  = r;
  endtask

  task automatic stepCycle(input string tag);
    @(posedge clock);
    #1;
    checkModel(tag);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    async_reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    table_v[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "en0_sr00"};
    table_v[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "en0_sr01"};
    table_v[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "en0_sr10"};
    table_v[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "en0_sr11"};
    table_v[4]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, "en1_reset"};
    table_v[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "en1_set"};
    table_v[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "en1_hold"};
    table_v[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "en1_forbid"};
    table_v[8]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "exit_by_en0"};
    table_v[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "forbid_again"};
    table_v[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, "exit_by_set"};
    table_v[11] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, "forbid_third"};
    table_v[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "exit_by_sr00"};
    table_v[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, "en0_set_ignored"};

    repeat (2) @(posedge clock);
    #1;
    checkOutput("reset_state", 1'b0, 1'b1, 1'b0);
    checkModel("reset_model");
    async_reset = 1'b0;

    for (int v = 0; v < 14; v++) begin
      applyStimulus(table_v[v].en, table_v[v].s, table_v[v].r);
      for (int c = 0; c < HOLD; c++) stepCycle(table_v[v].name);
      checkOutput(table_v[v].name, table_v[v].expQ, table_v[v].expQb, table_v[v].expF);
    end

    // Latency: a set must not show until SYNC+1 edges after it is applied.
    applyStimulus(1'b1, 1'b1, 1'b0);
    for (int c = 0; c < SYNC; c++) begin
      stepCycle("latency_wait");
      checkOutput("latency_early", 1'b0, 1'b1, 1'b0);
    end
    stepCycle("latency_edge");
    checkOutput("latency_arrive", 1'b1, 1'b0, 1'b0);

    // Mid-cycle async reset takes effect before any clock edge.
    applyStimulus(1'b0, 1'b0, 1'b0);
    stepCycle("hold_q1");
    checkOutput("hold_q1_const", 1'b1, 1'b0, 1'b0);
    #3;
    async_reset = 1'b1;
    #1;
    checkOutput("async_reset_mid", 1'b0, 1'b1, 1'b0);
    checkModel("async_reset_model");
    #1;
    async_reset = 1'b0;
    for (int c = 0; c < 4; c++) stepCycle("after_async_reset");
    checkOutput("after_async_reset_const", 1'b0, 1'b1, 1'b0);

`ifdef LATCH_SR_FORBIDDEN_STICKY_EN
    applyStimulus(1'b1, 1'b1, 1'b1);
    for (int c = 0; c < SYNC + 1; c++) stepCycle("sticky_enter");
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int c = 0; c < SYNC + 3; c++) stepCycle("sticky_exit");
    vectors++;
    if (forbidden_seen !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sticky_held: got %b, expected 1", forbidden_seen);
    end
    #3;
    async_reset = 1'b1;
    #1;
    vectors++;
    if (forbidden_seen !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sticky_cleared: got %b, expected 0", forbidden_seen);
    end
    #1;
    async_reset = 1'b0;
`endif

    for (int c = 0; c < 400; c++) begin
      applyStimulus($urandom_range(0, 3) != 0, 1'($urandom), 1'($urandom));
      stepCycle("random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
